csr_counter_bank: RTL and testbench
===================================

# csr_counter_bank

Parametrised machine/user counter CSR bank for the RV32I pipeline: `mcycle`, `minstret` and `NUM_HPM` event-driven `mhpmcounter` registers, each `CNT_WIDTH` bits wide. Adds software write access, `mcountinhibit` and per-counter event selection (`mhpmevent`), a registered one-cycle read port and wrap pulses. It sits beside the ID/EX stage. The CSR decode path drives its access port, and the retire and event strobes come from the pipeline control (flush-qualified).

## Interface
Parameters:
- `DATA_WIDTH`, 32, CSR data width (RV32).
- `CNT_WIDTH`, 64, counter width; legal range 33..64; bits above `CNT_WIDTH-1` read as 0.
- `NUM_HPM`, 4, number of `mhpmcounter3..` instances; legal range 0..29.
- `NUM_EVENTS`, 8, width of `event_i`; event selector codes are 1..`NUM_EVENTS`, and code 0 means no event.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `retire_i`  in  1  one instruction retired this cycle (already flush-qualified).
- `event_i`  in  `NUM_EVENTS`  event strobes; bit k corresponds to selector code k+1.
- `csr_addr_i`  in  12  CSR address.
- `csr_re_i`  in  1  read request.
- `csr_we_i`  in  1  write request; may coincide with `csr_re_i`.
- `csr_wdata_i`  in  `DATA_WIDTH`  write data.
- `csr_rdata_o`  out  `DATA_WIDTH`  registered read data.
- `csr_rvalid_o`  out  1  read data valid; high one cycle after `csr_re_i`.
- `csr_err_o`  out  1  registered access error: unmapped address, or write to a read-only address.
- `wrap_o`  out  `NUM_HPM+2`  one-cycle pulse when a counter wraps to 0. Bit 0 is cycle, bit 1 is instret, bit 2+i is hpm i.

## Operation
- Address map, machine read/write:
  - `mcycle` 0xB00 / `mcycleh` 0xB80.
  - `minstret` 0xB02 / `minstreth` 0xB82.
  - `mhpmcounter(3+i)` 0xB03+i / high half 0xB83+i.
  - `mcountinhibit` 0x320.
  - `mhpmevent(3+i)` 0x323+i.
- Address map, user read-only shadows: `cycle` 0xC00/0xC80, `instret` 0xC02/0xC82, `hpmcounter(3+i)` 0xC03+i / 0xC83+i.
- `mcountinhibit` layout:
  - Bit 0 inhibits cycle, bit 2 inhibits instret, bit 3+i inhibits hpm i.
  - All other bits are hardwired 0; writes to them are ignored and they read back 0.
- Increment rules, applied per cycle:
  - cycle: +1 if not inhibited.
  - instret: +1 if `retire_i` and not inhibited.
  - hpm i: +1 if `sel[i]`≠0, `event_i[sel[i]-1]` is high, and hpm i is not inhibited.
- Arithmetic: all counters increment modulo 2^`CNT_WIDTH`. When an enabled increment takes a counter from all-ones to 0, the matching `wrap_o` bit pulses.
- `mhpmevent` write: stores `csr_wdata_i[$clog2(NUM_EVENTS+1)-1:0]`. If that value exceeds `NUM_EVENTS`, 0 is stored instead. Reads return the stored selector, zero-extended.
- Counter write:
  - Replaces the addressed 32-bit half; the other half keeps its value.
  - The written counter does not increment in the write cycle, even if its increment condition holds.
  - Other counters are unaffected.
- Write to `mcountinhibit` takes effect for increments from the next cycle onward.
- Error handling:
  - A read of an unmapped address returns 0 and sets `csr_err_o` with `csr_rvalid_o`.
  - A write to a 0xCxx address or an unmapped address changes no state; `csr_err_o` pulses the next cycle.
- Read-during-write to the same address returns the pre-write value.

## Timing
- Reset value of all outputs is 0.
- Reset value of all state: all counters 0, `mcountinhibit` 0, all selectors 0.
- The first increment happens on the first edge with `rst_i` low.
- Read latency is 1 cycle: data is sampled at the `csr_re_i` edge and presented on `csr_rdata_o`/`csr_rvalid_o` for exactly one cycle. Back-to-back reads are allowed every cycle.
- Between reads, `csr_rdata_o` holds its last value and `csr_rvalid_o` is 0.
- `wrap_o` and `csr_err_o` are registered one-cycle pulses.
- Reset asserted mid-operation clears everything at that edge and discards any pending read/valid.
- No stall input: an access completes unconditionally.

## Structure
- Shared package `csr_pkg`:
  - CSR address constants (base addresses for `mcycle`, `minstret`, the hpm counters, their high halves, `mcountinhibit` and `mhpmevent`).
  - Offset 0x80 for high halves, 0xC00 for user shadows.
  - `DATA_WIDTH`/`CNT_WIDTH` defaults.
- Sub-module `csr_counter`: one `CNT_WIDTH` counter with `inc_i`, `we_lo_i`, `we_hi_i`, `wdata_i`, `value_o`, `wrap_o`. Instantiated `NUM_HPM+2` times via generate.
- Top level contains the address decode, inhibit/selector registers, the read mux and the output registers.

## Test plan
- Reset, then 10 idle cycles, then read 0xB00 → `csr_rdata_o`=10 with `csr_rvalid_o` high one cycle after `csr_re_i`. A read of 0xC02 returns 0.
- Write 0xB00=0xFFFF_FFFE and 0xB80=0xFFFF_FFFF, then run → the counter wraps; `wrap_o[0]` pulses on the edge where the value becomes 0. Then read 0xB80 → 0.
- Write `mhpmevent3`=2, toggle `event_i[1]` high for 5 cycles and `event_i[0]` high for 3 cycles → read 0xB03 = 5. Writing `mhpmevent3`=`NUM_EVENTS`+1 then reads back 0 and the counter stops.
- Write `mcountinhibit`=0x5 while `retire_i` is held high → cycle and instret freeze from the next cycle; hpm counters keep counting. Read 0x320 → 0x5.
- Write 0xC00 with data 0x1234 → counter unchanged, `csr_err_o` pulses. Read 0x7FF → `rdata`=0, `csr_err_o`=1.
- Write 0xB02=100 in the same cycle as `retire_i`=1 → read value 100, not 101. Assert `rst_i` during a pending read → `csr_rvalid_o` stays 0 and all counters read 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and address helpers for the performance-counter CSR bank.
package csr_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 64;

  // Machine counter addresses (low halves) and their high halves
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_MHPMCOUNTER3H = 12'hB83;

  // Control registers
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MHPMEVENT3    = 12'h323;

  // High halves sit 0x80 above the low half; user shadows mirror 0xBxx at 0xCxx
  localparam logic [11:0] HI_OFFSET     = 12'h080;
  localparam logic [11:0] MACH_CNT_BASE = 12'hB00;
  localparam logic [11:0] USER_BASE     = 12'hC00;

  // Counter index: 0 = cycle, 1 = instret, 2+i = hpm i
  typedef enum logic [1:0] {
    CNT_KIND_CYCLE   = 2'd0,
    CNT_KIND_INSTRET = 2'd1,
    CNT_KIND_HPM     = 2'd2
  } cnt_kind_e;

  function automatic cnt_kind_e cnt_kind(input int idx);
    cnt_kind_e k;
    if (idx == 0) begin
      k = CNT_KIND_CYCLE;
    end else if (idx == 1) begin
      k = CNT_KIND_INSTRET;
    end else begin
      k = CNT_KIND_HPM;
    end
    return k;
  endfunction

  // Low-half machine address of counter idx
  function automatic logic [11:0] cnt_lo_addr(input int idx);
    logic [11:0] a;
    case (cnt_kind(idx))
      CNT_KIND_CYCLE:   a = ADDR_MCYCLE;
      CNT_KIND_INSTRET: a = ADDR_MINSTRET;
      CNT_KIND_HPM:     a = ADDR_MHPMCOUNTER3 + 12'(idx - 2);
      default:          a = ADDR_MCYCLE;
    endcase
    return a;
  endfunction

  // mcountinhibit bit for counter idx (bit 1 is the reserved time slot)
  function automatic int inhibit_bit(input int idx);
    return (idx == 0) ? 0 : idx + 1;
  endfunction

  // Writable bits of mcountinhibit for a bank with num_hpm event counters
  function automatic logic [31:0] inhibit_mask(input int num_hpm);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int j = 0; j < num_hpm + 2; j++) begin
      m = m | (32'h0000_0001 << inhibit_bit(j));
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// One wide counter with half-word software writes and a registered wrap pulse.
module csr_counter
  import csr_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inc_i,
  input  logic                  we_lo_i,
  input  logic                  we_hi_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [CNT_WIDTH-1:0]  value_o,
  output logic                  wrap_o
);

  localparam int HI_W = CNT_WIDTH - 32;
  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_nxt_s;
  logic                 wrap_r;
  logic                 wrap_nxt_s;

  // Next value: a software write to either half suppresses this cycle's increment
  always_comb begin
    cnt_nxt_s  = cnt_r;
    wrap_nxt_s = 1'b0;
    if (we_lo_i || we_hi_i) begin
      if (we_lo_i) begin
        cnt_nxt_s[31:0] = wdata_i[31:0];
      end else begin
        cnt_nxt_s[31:0] = cnt_r[31:0];
      end
      if (we_hi_i) begin
        cnt_nxt_s[CNT_WIDTH-1:32] = wdata_i[HI_W-1:0];
      end else begin
        cnt_nxt_s[CNT_WIDTH-1:32] = cnt_r[CNT_WIDTH-1:32];
      end
    end else if (inc_i) begin
      cnt_nxt_s  = cnt_r + ONE;
      wrap_nxt_s = &cnt_r;
    end else begin
      cnt_nxt_s  = cnt_r;
      wrap_nxt_s = 1'b0;
    end
  end

  // Counter and wrap pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r  <= '0;
      wrap_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      wrap_r <= wrap_nxt_s;
    end
  end

  assign value_o = cnt_r;
  assign wrap_o  = wrap_r;

endmodule

// File: rtl/csr_counter_bank.sv
// Machine/user counter CSR bank: decode, inhibit and event selectors, read port.
module csr_counter_bank
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  retire_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [11:0]           csr_addr_i,
  input  logic                  csr_re_i,
  input  logic                  csr_we_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  output logic                  csr_rvalid_o,
  output logic                  csr_err_o,
  output logic [NUM_HPM+1:0]    wrap_o
);

  localparam int NCNT  = NUM_HPM + 2;
  localparam int NSEL  = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int SEL_W = $clog2(NUM_EVENTS + 1);
  localparam logic [SEL_W-1:0]      SEL_MAX  = SEL_W'(NUM_EVENTS);
  localparam logic [DATA_WIDTH-1:0] INH_MASK = inhibit_mask(NUM_HPM);

  logic [DATA_WIDTH-1:0] inhibit_r;
  logic                  inh_hit_s;

  logic [NCNT-1:0] inc_s;
  logic [NCNT-1:0] we_lo_s;
  logic [NCNT-1:0] we_hi_s;
  logic [NCNT-1:0] wrap_s;
  logic [NCNT-1:0] cnt_mach_hit_s;
  logic [NCNT-1:0] cnt_any_hit_s;
  logic [DATA_WIDTH-1:0] cnt_or_s [NCNT+1];

  logic [NSEL-1:0]       sel_hit_s;
  logic [NSEL-1:0]       ev_hit_s;
  logic [DATA_WIDTH-1:0] sel_or_s [NSEL+1];
  logic [SEL_W-1:0]      sel_wdata_s;

  logic                  rd_map_s;
  logic                  wr_map_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  rvalid_r;
  logic                  err_r;

  assign inh_hit_s   = (csr_addr_i == ADDR_MCOUNTINHIBIT);
  assign cnt_or_s[0] = '0;
  assign sel_or_s[0] = '0;

  // Event selector registers, one per hpm counter
  for (genvar i = 0; i < NSEL; i++) begin : g_sel
    if (i < NUM_HPM) begin : g_real
      localparam logic [11:0] EV_ADDR = ADDR_MHPMEVENT3 + 12'(i);
      logic [SEL_W-1:0]      sel_r;
      logic [NUM_EVENTS-1:0] match_s;

      assign sel_hit_s[i] = (csr_addr_i == EV_ADDR);

      // Selector update; out-of-range codes were already folded to 0
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sel_r <= '0;
        end else if (csr_we_i && sel_hit_s[i]) begin
          sel_r <= sel_wdata_s;
        end else begin
          sel_r <= sel_r;
        end
      end

      for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_ev
        assign match_s[k] = event_i[k] && (sel_r == SEL_W'(k + 1));
      end

      assign ev_hit_s[i]   = |match_s;
      assign sel_or_s[i+1] = sel_or_s[i] |
                             (sel_hit_s[i] ? DATA_WIDTH'(sel_r) : {DATA_WIDTH{1'b0}});
    end else begin : g_tie
      assign sel_hit_s[i]  = 1'b0;
      assign ev_hit_s[i]   = 1'b0;
      assign sel_or_s[i+1] = sel_or_s[i];
    end
  end

  // Counters with their address decode and increment qualification
  for (genvar j = 0; j < NCNT; j++) begin : g_cnt
    localparam logic [11:0] LO  = cnt_lo_addr(j);
    localparam logic [11:0] HI  = LO + HI_OFFSET;
    localparam logic [11:0] ULO = LO - MACH_CNT_BASE + USER_BASE;
    localparam logic [11:0] UHI = ULO + HI_OFFSET;
    localparam int          IB  = inhibit_bit(j);

    logic [CNT_WIDTH-1:0] value_s;
    logic [63:0]          ext_s;
    logic                 rd_lo_s;
    logic                 rd_hi_s;

    assign rd_lo_s = (csr_addr_i == LO) || (csr_addr_i == ULO);
    assign rd_hi_s = (csr_addr_i == HI) || (csr_addr_i == UHI);
    assign cnt_mach_hit_s[j] = (csr_addr_i == LO) || (csr_addr_i == HI);
    assign cnt_any_hit_s[j]  = rd_lo_s || rd_hi_s;
    assign we_lo_s[j] = csr_we_i && (csr_addr_i == LO);
    assign we_hi_s[j] = csr_we_i && (csr_addr_i == HI);

    if (j == 0) begin : g_cyc
      assign inc_s[j] = ~inhibit_r[IB];
    end else if (j == 1) begin : g_ret
      assign inc_s[j] = retire_i && ~inhibit_r[IB];
    end else begin : g_hpm
      assign inc_s[j] = ev_hit_s[j-2] && ~inhibit_r[IB];
    end

    assign ext_s = 64'(value_s);
    assign cnt_or_s[j+1] = cnt_or_s[j] |
                           (rd_lo_s ? ext_s[31:0]  : {DATA_WIDTH{1'b0}}) |
                           (rd_hi_s ? ext_s[63:32] : {DATA_WIDTH{1'b0}});

    csr_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (inc_s[j]),
      .we_lo_i(we_lo_s[j]),
      .we_hi_i(we_hi_s[j]),
      .wdata_i(csr_wdata_i),
      .value_o(value_s),
      .wrap_o (wrap_s[j])
    );
  end

  // Selector write value: codes above NUM_EVENTS mean "no event"
  always_comb begin
    sel_wdata_s = csr_wdata_i[SEL_W-1:0];
    if (csr_wdata_i[SEL_W-1:0] > SEL_MAX) begin
      sel_wdata_s = '0;
    end else begin
      sel_wdata_s = csr_wdata_i[SEL_W-1:0];
    end
  end

  // Address map membership and read mux (values before any same-cycle write)
  always_comb begin
    rd_map_s  = (|cnt_any_hit_s) || inh_hit_s || (|sel_hit_s);
    wr_map_s  = (|cnt_mach_hit_s) || inh_hit_s || (|sel_hit_s);
    rd_data_s = '0;
    if (rd_map_s) begin
      rd_data_s = cnt_or_s[NCNT] | sel_or_s[NSEL] |
                  (inh_hit_s ? inhibit_r : {DATA_WIDTH{1'b0}});
    end else begin
      rd_data_s = '0;
    end
  end

  // mcountinhibit: only implemented bits are stored
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inhibit_r <= '0;
    end else if (csr_we_i && inh_hit_s) begin
      inhibit_r <= csr_wdata_i & INH_MASK;
    end else begin
      inhibit_r <= inhibit_r;
    end
  end

  // Read port and error pulse; rdata holds between reads
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= csr_re_i;
      if (csr_re_i) begin
        rdata_r <= rd_data_s;
      end else begin
        rdata_r <= rdata_r;
      end
      err_r <= (csr_re_i && !rd_map_s) || (csr_we_i && !wr_map_s);
    end
  end

  assign csr_rdata_o  = rdata_r;
  assign csr_rvalid_o = rvalid_r;
  assign csr_err_o    = err_r;
  assign wrap_o       = wrap_s;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed scoreboard bench for csr_counter_bank.
module tb_csr_counter_bank;

  logic        clk;
  logic        rst;
  logic        retire;
  logic [7:0]  event_v;
  logic [11:0] csr_addr;
  logic        csr_re;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        csr_err;
  logic [5:0]  wrap;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  string       tagq[$];
  logic [31:0] last_rdata;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  csr_counter_bank #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (64),
    .NUM_HPM   (4),
    .NUM_EVENTS(8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .retire_i    (retire),
    .event_i     (event_v),
    .csr_addr_i  (csr_addr),
    .csr_re_i    (csr_re),
    .csr_we_i    (csr_we),
    .csr_wdata_i (csr_wdata),
    .csr_rdata_o (csr_rdata),
    .csr_rvalid_o(csr_rvalid),
    .csr_err_o   (csr_err),
    .wrap_o      (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = sbq.pop_front();
    t = tagq.pop_front();
    check({t, "_rvalid"}, 64'(csr_rvalid), 64'(e.rvalid));
    check({t, "_rdata"},  64'(csr_rdata),  64'(e.rdata));
    check({t, "_err"},    64'(csr_err),    64'(e.err));
  endtask

  task automatic csr_read(input logic [11:0] addr, input logic [31:0] exp_d,
                          input logic exp_err, input string tag);
    csr_addr = addr;
    csr_re   = 1'b1;
    sbq.push_back('{rvalid: 1'b1, rdata: exp_d, err: exp_err});
    tagq.push_back(tag);
    last_rdata = exp_d;
    cyc();
    csr_re = 1'b0;
    pop_check();
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic exp_err, input string tag);
    csr_addr  = addr;
    csr_wdata = data;
    csr_we    = 1'b1;
    sbq.push_back('{rvalid: 1'b0, rdata: last_rdata, err: exp_err});
    tagq.push_back(tag);
    cyc();
    csr_we = 1'b0;
    pop_check();
  endtask

  task automatic csr_rw(input logic [11:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_d, input string tag);
    csr_addr  = addr;
    csr_wdata = data;
    csr_we    = 1'b1;
    csr_re    = 1'b1;
    sbq.push_back('{rvalid: 1'b1, rdata: exp_d, err: 1'b0});
    tagq.push_back(tag);
    last_rdata = exp_d;
    cyc();
    csr_we = 1'b0;
    csr_re = 1'b0;
    pop_check();
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    n_fail     = 0;
    last_rdata = 32'h0;
    rst        = 1'b1;
    retire     = 1'b0;
    event_v    = 8'h00;
    csr_addr   = 12'h000;
    csr_re     = 1'b0;
    csr_we     = 1'b0;
    csr_wdata  = 32'h0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_rdata",  64'(csr_rdata),  64'h0);
    check("rst_rvalid", 64'(csr_rvalid), 64'h0);
    check("rst_err",    64'(csr_err),    64'h0);
    check("rst_wrap",   64'(wrap),       64'h0);
    rst = 1'b0;

    // 10 idle cycles, then mcycle reads 10
    repeat (10) cyc();
    csr_read(12'hB00, 32'd10, 1'b0, "mcycle_10");
    cyc();
    check("idle_rvalid", 64'(csr_rvalid), 64'h0);
    check("hold_rdata",  64'(csr_rdata),  64'd10);
    csr_read(12'hC02, 32'd0, 1'b0, "instret_0");

    // mcycle wrap
    csr_write(12'hB00, 32'hFFFF_FFFE, 1'b0, "w_mcycle");
    csr_write(12'hB80, 32'hFFFF_FFFF, 1'b0, "w_mcycleh");
    cyc();
    check("wrap_pre", 64'(wrap), 64'h00);
    cyc();
    check("wrap_cycle", 64'(wrap), 64'h01);
    csr_read(12'hB80, 32'd0, 1'b0, "mcycleh_after_wrap");
    check("wrap_post", 64'(wrap), 64'h00);

    // event-driven hpm0 with selector 2
    csr_read(12'hB03, 32'd0, 1'b0, "hpm0_init");
    csr_write(12'h323, 32'd2, 1'b0, "w_ev3");
    event_v = 8'b0000_0011;
    repeat (3) cyc();
    event_v = 8'b0000_0010;
    repeat (2) cyc();
    event_v = 8'h00;
    csr_read(12'hB03, 32'd5, 1'b0, "hpm0_5");
    csr_read(12'h323, 32'd2, 1'b0, "ev3_2");
    csr_read(12'hC03, 32'd5, 1'b0, "hpm0_user");
    csr_write(12'h323, 32'd9, 1'b0, "w_ev3_oor");
    csr_read(12'h323, 32'd0, 1'b0, "ev3_oor_0");
    event_v = 8'b0000_0010;
    repeat (3) cyc();
    event_v = 8'h00;
    csr_read(12'hB03, 32'd5, 1'b0, "hpm0_stopped");
    csr_write(12'h323, 32'd8, 1'b0, "w_ev3_max");
    csr_read(12'h323, 32'd8, 1'b0, "ev3_max");
    csr_write(12'h323, 32'h12, 1'b0, "w_ev3_trunc");
    csr_read(12'h323, 32'd2, 1'b0, "ev3_trunc");

    // inhibit cycle and instret while retiring; hpm keeps counting
    retire = 1'b1;
    csr_write(12'h320, 32'h5, 1'b0, "w_inhibit");
    event_v = 8'b0000_0010;
    repeat (4) cyc();
    event_v = 8'h00;
    csr_read(12'hB02, 32'd1, 1'b0, "instret_frozen");
    csr_read(12'hB03, 32'd9, 1'b0, "hpm0_counts");
    csr_read(12'h320, 32'h5, 1'b0, "inhibit_rb");
    csr_write(12'hB00, 32'h77, 1'b0, "w_mcycle_77");
    repeat (3) cyc();
    csr_read(12'hB00, 32'h77, 1'b0, "mcycle_frozen");

    // errors: user-shadow and unmapped accesses
    csr_write(12'hC00, 32'h1234, 1'b1, "w_user_err");
    csr_read(12'hB00, 32'h77, 1'b0, "mcycle_unchanged");
    csr_write(12'hC02, 32'h5, 1'b1, "w_user_instret_err");
    csr_read(12'h7FF, 32'h0, 1'b1, "r_unmapped");
    csr_write(12'h7FF, 32'h1, 1'b1, "w_unmapped");

    // read-during-write returns the old value
    csr_rw(12'hB00, 32'h99, 32'h77, "rw_mcycle");
    csr_read(12'hB00, 32'h99, 1'b0, "mcycle_new");

    // only implemented inhibit bits stick
    csr_write(12'h320, 32'hFFFF_FFFF, 1'b0, "w_inhibit_all");
    csr_read(12'h320, 32'h7D, 1'b0, "inhibit_mask");
    csr_write(12'h320, 32'h0, 1'b0, "w_inhibit_clr");

    // write beats a same-cycle retire
    csr_write(12'hB02, 32'd100, 1'b0, "w_minstret");
    csr_read(12'hB02, 32'd100, 1'b0, "minstret_100");
    retire = 1'b0;
    csr_read(12'hB02, 32'd101, 1'b0, "minstret_101");

    // hpm0 wrap pulse
    csr_write(12'hB83, 32'hFFFF_FFFF, 1'b0, "w_hpm0h");
    csr_write(12'hB03, 32'hFFFF_FFFF, 1'b0, "w_hpm0l");
    event_v = 8'b0000_0010;
    cyc();
    check("wrap_hpm0", 64'(wrap), 64'h04);
    event_v = 8'h00;
    cyc();
    check("wrap_hpm0_clr", 64'(wrap), 64'h00);
    csr_read(12'hB83, 32'd0, 1'b0, "hpm0h_wrapped");

    // reset during a read discards it and clears all state
    csr_addr = 12'hB00;
    csr_re   = 1'b1;
    rst      = 1'b1;
    cyc();
    csr_re = 1'b0;
    check("rst_rd_rvalid", 64'(csr_rvalid), 64'h0);
    check("rst_rd_rdata",  64'(csr_rdata),  64'h0);
    check("rst_rd_err",    64'(csr_err),    64'h0);
    cyc();
    rst        = 1'b0;
    last_rdata = 32'h0;
    csr_read(12'hB00, 32'd0, 1'b0, "rst_mcycle");
    csr_read(12'hB02, 32'd0, 1'b0, "rst_minstret");
    csr_read(12'hB03, 32'd0, 1'b0, "rst_hpm0");
    csr_read(12'hB83, 32'd0, 1'b0, "rst_hpm0h");
    csr_read(12'h320, 32'd0, 1'b0, "rst_inhibit");
    csr_read(12'h323, 32'd0, 1'b0, "rst_ev3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
